// File: rtl/i2c_color_target.sv
// I2C target model of the colour sensor: address match, register-pointer write, 16-bit channel reads.
// Optional macro I2C_TGT_AUTOINC_EN: pointer advances after every completed word read.
`timescale 1ns/1ps
module i2c_color_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_CH      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] clear_data,
  input  logic [15:0] red_data,
  input  logic [15:0] green_data,
  input  logic [15:0] blue_data,
  input  logic [15:0] infrared_data,
  output logic [2:0]  reg_ptr,
  output logic        busy,
  output logic        rd_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_e;

  // Synchronisers reset to the idle bus level so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  rx_next;
  logic [15:0] tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        hi_q, hi_d;
  logic        ack_seen_q, ack_seen_d;
  logic        ack_ok_q, ack_ok_d;
  logic        ptr_wr_q, ptr_wr_d;
  logic        sda_oe_q, sda_oe_d;
  logic [2:0]  reg_ptr_q, reg_ptr_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;
  logic [15:0] word_sel;
  logic [2:0]  ptr_after_word;

  assign rx_next = {rx_q, sda_s};

  always_comb begin
    word_sel = '0;
    case (reg_ptr_q)
      3'd0:    word_sel = clear_data;
      3'd1:    word_sel = red_data;
      3'd2:    word_sel = green_data;
      3'd3:    word_sel = blue_data;
      3'd4:    word_sel = infrared_data;
      default: word_sel = '0;
    endcase
  end

`ifdef I2C_TGT_AUTOINC_EN
  always_comb begin
    ptr_after_word = reg_ptr_q + 3'd1;
    if (reg_ptr_q == 3'(NUM_CH - 1)) ptr_after_word = '0;
  end
`else
  always_comb begin
    ptr_after_word = reg_ptr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      hi_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      ack_ok_q   <= 1'b0;
      ptr_wr_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      reg_ptr_q  <= '0;
      busy_q     <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      hi_q       <= hi_d;
      ack_seen_q <= ack_seen_d;
      ack_ok_q   <= ack_ok_d;
      ptr_wr_q   <= ptr_wr_d;
      sda_oe_q   <= sda_oe_d;
      reg_ptr_q  <= reg_ptr_d;
      busy_q     <= busy_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Bits are sampled on SCL rise; SDA drive only changes on SCL fall.
  // ACK states use ack_seen_q: first fall drives the ACK slot, the fall after its rise leaves.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    hi_d       = hi_q;
    ack_seen_d = ack_seen_q;
    ack_ok_d   = ack_ok_q;
    ptr_wr_d   = ptr_wr_q;
    sda_oe_d   = sda_oe_q;
    reg_ptr_d  = reg_ptr_q;
    busy_d     = busy_q;
    rd_done_d  = 1'b0;

    if (stop_det) begin
      state_d    = IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      ack_seen_d = 1'b0;
    end else if (start_det) begin
      state_d    = ADDR;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
      ack_seen_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              rw_d      = sda_s;
              state_d   = (rx_next[7:1] == dev_addr) ? ADDR_ACK : IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_oe_d = 1'b1;
            end else begin
              ack_seen_d = 1'b0;
              if (rw_q) begin
                tx_d     = {word_sel[14:0], 1'b0};
                sda_oe_d = ~word_sel[15];
                hi_d     = 1'b1;
                state_d  = RD_BYTE;
              end else begin
                sda_oe_d = 1'b0;
                ptr_wr_d = 1'b1;
                state_d  = WR_BYTE;
              end
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            rx_d      = rx_next[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = WR_ACK;
              ack_ok_d  = 1'b1;
              if (ptr_wr_q) begin
                ptr_wr_d = 1'b0;
                if (rx_next < 8'(NUM_CH)) reg_ptr_d = rx_next[2:0];
                else                      ack_ok_d  = 1'b0;
              end
            end
          end
        end
        WR_ACK: begin
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_oe_d = ack_ok_q;
            end else begin
              ack_seen_d = 1'b0;
              sda_oe_d   = 1'b0;
              state_d    = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end
          end else if (scl_fall) begin
            sda_oe_d = ~tx_q[15];
            tx_d     = {tx_q[14:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!hi_q) begin
              rd_done_d = 1'b1;
              reg_ptr_d = ptr_after_word;
            end
            if (sda_s) begin
              state_d  = IGNORE;
              sda_oe_d = 1'b0;
            end else begin
              ack_seen_d = 1'b1;
            end
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_oe_d = 1'b0;
            end else begin
              ack_seen_d = 1'b0;
              state_d    = RD_BYTE;
              if (hi_q) begin
                hi_d     = 1'b0;
                sda_oe_d = ~tx_q[15];
                tx_d     = {tx_q[14:0], 1'b0};
              end else begin
                // Fresh snapshot per word, using the pointer already advanced on the ACK rise.
                hi_d     = 1'b1;
                tx_d     = {word_sel[14:0], 1'b0};
                sda_oe_d = ~word_sel[15];
              end
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe  = sda_oe_q;
  assign reg_ptr = reg_ptr_q;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;

endmodule

// File: tb/tb_i2c_color_target.sv
// Bench for i2c_color_target: bit-banged I2C master plus channel/pointer reference model.
`timescale 1ns/1ps
module tb_i2c_color_target;

`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [6:0]  addr7;
  logic [15:0] ch_m [0:4];
  logic [2:0]  reg_ptr;
  logic        busy;
  logic        rd_done;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int oe_cnt = 0;
  int model_ptr = 0;
  logic [15:0] rd_words  [0:3];
  logic [15:0] exp_words [0:3];

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  always @(posedge clk) if (rd_done === 1'b1) rd_cnt++;
  always @(negedge clk) if (sda_oe === 1'b1) oe_cnt++;

  i2c_color_target #(.SYNC_STAGES(2), .NUM_CH(5)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .dev_addr(addr7), .clear_data(ch_m[0]), .red_data(ch_m[1]), .green_data(ch_m[2]),
    .blue_data(ch_m[3]), .infrared_data(ch_m[4]), .reg_ptr(reg_ptr), .busy(busy),
    .rd_done(rd_done)
  );

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input bit b);
    sda_m = b;  tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output bit b);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    b = sda_line; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output bit acked);
    bit b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    acked = !b;
  endtask

  task automatic read_byte(output logic [7:0] v, input bit master_ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(!master_ack);
  endtask

  // Model: a pointer write below the channel count is accepted, anything else refused.
  task automatic set_ptr(input logic [7:0] v, output bit a_ack, output bit p_ack);
    i2c_start();
    write_byte({addr7, 1'b0}, a_ack);
    write_byte(v, p_ack);
    i2c_stop();
    if (v < 8'd5) model_ptr = int'(v);
  endtask

  // Model: each word returns the channel under the pointer; with auto-increment it then advances mod 5.
  task automatic model_read(input int n);
    int p;
    p = model_ptr;
    for (int w = 0; w < n; w++) begin
      exp_words[w] = ch_m[p];
      if (AUTOINC) p = (p + 1) % 5;
    end
    model_ptr = p;
  endtask

  task automatic read_words(input int n, output bit a_ack);
    logic [7:0] hi, lo;
    i2c_start();
    write_byte({addr7, 1'b1}, a_ack);
    for (int w = 0; w < n; w++) begin
      read_byte(hi, 1'b1);
      read_byte(lo, w < n - 1);
      rd_words[w] = {hi, lo};
    end
    i2c_stop();
  endtask

  task automatic test_reset();
    bit a, p, b;
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; addr7 = 7'h39;
    for (int i = 0; i < 5; i++) ch_m[i] = 16'h0000;
    tick(4);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (reg_ptr !== 3'd0) begin errors++; $display("FAIL reset_reg_ptr: got %0d expected 0", reg_ptr); end
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_rd_done: got %b expected 0", rd_done); end
    rst_n = 1'b1; tick(4);
    set_ptr(8'd3, a, p);
    i2c_start();
    write_byte({addr7, 1'b1}, a);
    for (int i = 0; i < 3; i++) read_bit(b);
    checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_drive: got %b expected 1", sda_oe); end
    rst_n = 1'b0; #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midreset_sda_oe: got %b expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (reg_ptr !== 3'd0) begin errors++; $display("FAIL midreset_reg_ptr: got %0d expected 0", reg_ptr); end
    scl = 1'b1; sda_m = 1'b1; tick(4);
    rst_n = 1'b1; tick(4);
    model_ptr = 0;
  endtask

  task automatic test_address();
    bit a;
    int oe0;
    logic [6:0] probe;
    i2c_start();
    write_byte(8'h72, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL addr_match_ack: got %b expected 1", a); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL addr_busy: got %b expected 1", busy); end
    i2c_stop();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    i2c_start();
    oe0 = oe_cnt;
    write_byte(8'h74, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL addr_miss_ack: got %b expected 0", a); end
    write_byte(8'h00, a);
    i2c_stop();
    checks++; if (oe_cnt !== oe0) begin errors++; $display("FAIL addr_miss_released: got %0d drive cycles expected 0", oe_cnt - oe0); end
    for (int k = 0; k < 4; k++) begin
      addr7 = 7'($urandom);
      probe = ($urandom_range(0, 1) == 1) ? addr7 : 7'($urandom);
      i2c_start();
      write_byte({probe, 1'b0}, a);
      i2c_stop();
      checks++;
      if (a !== (probe == addr7)) begin
        errors++; $display("FAIL addr_rand: dev %h probe %h got ack %b expected %b", addr7, probe, a, probe == addr7);
      end
    end
    addr7 = 7'h39;
  endtask

  task automatic test_pointer();
    bit a, p;
    logic [7:0] v;
    set_ptr(8'h02, a, p);
    checks++; if (a !== 1'b1 || p !== 1'b1) begin errors++; $display("FAIL ptr2_acks: got %b%b expected 11", a, p); end
    checks++; if (reg_ptr !== 3'd2) begin errors++; $display("FAIL ptr2_value: got %0d expected 2", reg_ptr); end
    set_ptr(8'h07, a, p);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL ptr7_nack: got ack %b expected 0", p); end
    checks++; if (reg_ptr !== 3'd2) begin errors++; $display("FAIL ptr7_keep: got %0d expected 2", reg_ptr); end
    i2c_start();
    write_byte({addr7, 1'b0}, a);
    write_byte(8'h01, p);
    write_byte(8'($urandom), a);
    i2c_stop();
    model_ptr = 1;
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL extra_byte_ack: got %b expected 1", a); end
    checks++; if (reg_ptr !== 3'd1) begin errors++; $display("FAIL extra_byte_ptr: got %0d expected 1", reg_ptr); end
    for (int k = 0; k < 4; k++) begin
      v = 8'($urandom_range(0, 9));
      if (k == 3) v = 8'($urandom_range(5, 255));
      set_ptr(v, a, p);
      checks++;
      if (p !== (v < 8'd5) || reg_ptr !== 3'(model_ptr)) begin
        errors++; $display("FAIL ptr_rand: v %0d got ack %b ptr %0d expected ack %b ptr %0d", v, p, reg_ptr, v < 8'd5, model_ptr);
      end
    end
  endtask

  task automatic test_read();
    bit a, p;
    int r0, n;
    ch_m[1] = 16'hA5C3;
    set_ptr(8'd1, a, p);
    r0 = rd_cnt;
    read_words(1, a);
    model_read(1);
    checks++; if (rd_words[0][15:8] !== 8'hA5) begin errors++; $display("FAIL read_hi: got %h expected a5", rd_words[0][15:8]); end
    checks++; if (rd_words[0][7:0] !== 8'hC3) begin errors++; $display("FAIL read_lo: got %h expected c3", rd_words[0][7:0]); end
    checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_rd_done: got %0d pulses expected 1", rd_cnt - r0); end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) ch_m[i] = 16'($urandom);
      set_ptr(8'($urandom_range(0, 4)), a, p);
      n = $urandom_range(1, 3);
      r0 = rd_cnt;
      model_read(n);
      read_words(n, a);
      for (int w = 0; w < n; w++) begin
        checks++;
        if (rd_words[w] !== exp_words[w]) begin
          errors++; $display("FAIL read_rand word %0d: got %h expected %h", w, rd_words[w], exp_words[w]);
        end
      end
      checks++;
      if (rd_cnt - r0 !== n || reg_ptr !== 3'(model_ptr)) begin
        errors++; $display("FAIL read_rand_state: got %0d pulses ptr %0d expected %0d pulses ptr %0d", rd_cnt - r0, reg_ptr, n, model_ptr);
      end
    end
  endtask

  task automatic test_autoinc();
    bit a, p;
    logic [15:0] exp1;
    for (int i = 0; i < 5; i++) ch_m[i] = 16'($urandom);
    set_ptr(8'd4, a, p);
    read_words(2, a);
    model_read(2);
    exp1 = AUTOINC ? ch_m[0] : ch_m[4];
    checks++; if (rd_words[0] !== ch_m[4]) begin errors++; $display("FAIL ptr4_word0: got %h expected %h", rd_words[0], ch_m[4]); end
    checks++; if (rd_words[1] !== exp1) begin errors++; $display("FAIL ptr4_word1: got %h expected %h", rd_words[1], exp1); end
    checks++;
    if (reg_ptr !== (AUTOINC ? 3'd1 : 3'd4)) begin
      errors++; $display("FAIL ptr4_after: got %0d expected %0d", reg_ptr, AUTOINC ? 1 : 4);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    logic [7:0] hi, lo, p;
    p = 8'($urandom_range(0, 4));
    i2c_start();
    write_byte({addr7, 1'b0}, a);
    write_byte(p, a);
    model_ptr = int'(p);
    i2c_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy: got %b expected 1", busy); end
    write_byte({addr7, 1'b1}, a);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL sr_addr_ack: got %b expected 1", a); end
    read_byte(hi, 1'b1);
    read_byte(lo, 1'b0);
    i2c_stop();
    model_read(1);
    checks++; if ({hi, lo} !== exp_words[0]) begin errors++; $display("FAIL sr_word: got %h expected %h", {hi, lo}, exp_words[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_stop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_tear();
    bit a, p;
    logic [7:0] hi, lo;
    ch_m[2] = 16'h1234;
    set_ptr(8'd2, a, p);
    i2c_start();
    write_byte({addr7, 1'b1}, a);
    read_byte(hi, 1'b1);
    ch_m[2] = 16'hBEEF;
    read_byte(lo, 1'b0);
    i2c_stop();
    checks++; if ({hi, lo} !== 16'h1234) begin errors++; $display("FAIL tear_old: got %h expected 1234", {hi, lo}); end
    set_ptr(8'd2, a, p);
    read_words(1, a);
    checks++; if (rd_words[0] !== 16'hBEEF) begin errors++; $display("FAIL tear_new: got %h expected beef", rd_words[0]); end
  endtask

  initial begin
    test_reset();
    test_address();
    test_pointer();
    test_read();
    test_autoinc();
    test_back_to_back();
    test_tear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
